// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller and its cycle timer:
// timer state encoding, nominal phase durations and wash mode encodings.
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timerState_t;

  localparam int unsigned FILL_TIME  = 5000000;
  localparam int unsigned WASH_TIME  = 15000000;
  localparam int unsigned RINSE_TIME = 10000000;
  localparam int unsigned SPIN_TIME  = 8000000;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    DELICATE   = 2'd1,
    HEAVY      = 2'd2,
    RINSE_ONLY = 2'd3
  } washMode_t;

endpackage

// File: rtl/wm_cycle_timer_if.sv
// Timer interface between the washing-machine controller (master) and
// the cycle timer (slave).
interface wm_cycle_timer_if
  import wm_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             timer_start;
  logic [CNT_W-1:0] timer_value;
  logic             hold;
  logic             abort;
  logic             timer_done;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             phase;

  modport master (
    output timer_start, timer_value, hold, abort,
    input  timer_done, busy, remaining, phase
  );

  modport slave (
    input  timer_start, timer_value, hold, abort,
    output timer_done, busy, remaining, phase
  );

endinterface

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles.
// Only instantiated when WM_CYCLE_TIMER_PRESCALE_EN is defined.
module wm_tick_prescaler
  import wm_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] r_count;

  assign o_tick = (r_count == LAST);

  // Count enabled cycles, wrapping after the tick; a clear restarts the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (o_tick) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/wm_cycle_timer.sv
// Programmable countdown timer answering the controller's timer interface.
// Define WM_CYCLE_TIMER_PRESCALE_EN to count ticks of PRESCALE_DIV clk
// cycles instead of single clk cycles.
module wm_cycle_timer
  import wm_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PHASE_LOG2   = 20,
  parameter int PRESCALE_DIV = 1000
) (
  input  logic               clk,
  input  logic               reset,
  wm_cycle_timer_if.slave    tif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Catch illegal configurations at elaboration time.
  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 65535) begin : g_badDiv
    $error("PRESCALE_DIV out of range");
  end
  if (PHASE_LOG2 < 0 || PHASE_LOG2 >= CNT_W) begin : g_badPhase
    $error("PHASE_LOG2 out of range");
  end

  timerState_t      r_state;
  timerState_t      w_stateNext;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remainingNext;
  logic [CNT_W-1:0] r_elapsed;
  logic [CNT_W-1:0] w_elapsedNext;
  logic             r_done;
  logic             w_doneNext;
  logic             w_tick;

`ifdef WM_CYCLE_TIMER_PRESCALE_EN
  logic w_prescaleTick;

  wm_tick_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (tif.abort | tif.timer_start),
    .i_enable ((r_state == RUN) && !tif.hold),
    .o_tick   (w_prescaleTick)
  );

  assign w_tick = (r_state == RUN) && w_prescaleTick;
`else
  assign w_tick = (r_state == RUN);
`endif

  // Next-state decode: abort beats start, start beats expiry, expiry beats hold.
  always_comb begin
    w_stateNext     = r_state;
    w_remainingNext = r_remaining;
    w_elapsedNext   = r_elapsed;
    w_doneNext      = 1'b0;
    if (tif.abort) begin
      w_stateNext     = IDLE;
      w_remainingNext = '0;
      w_elapsedNext   = '0;
    end else if (tif.timer_start) begin
      w_remainingNext = (tif.timer_value == '0) ? CNT_ONE : tif.timer_value;
      w_elapsedNext   = '0;
      w_stateNext     = tif.hold ? HOLD : RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_tick && (r_remaining == CNT_ONE)) begin
            w_remainingNext = '0;
            w_elapsedNext   = r_elapsed + CNT_ONE;
            w_doneNext      = 1'b1;
            w_stateNext     = IDLE;
          end else if (tif.hold) begin
            w_stateNext = HOLD;
          end else if (w_tick) begin
            w_remainingNext = r_remaining - CNT_ONE;
            w_elapsedNext   = r_elapsed + CNT_ONE;
          end
        end
        HOLD: begin
          if (!tif.hold) begin
            w_stateNext = RUN;
          end
        end
        default: begin
          w_stateNext     = IDLE;
          w_remainingNext = '0;
        end
      endcase
    end
  end

  // State, counters and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_elapsed   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_remaining <= w_remainingNext;
      r_elapsed   <= w_elapsedNext;
      r_done      <= w_doneNext;
    end
  end

  assign tif.timer_done = r_done;
  assign tif.busy       = (r_state == RUN) || (r_state == HOLD);
  assign tif.remaining  = r_remaining;
  assign tif.phase      = r_elapsed[PHASE_LOG2];

endmodule

// File: tb/tb_wm_cycle_timer.sv
// Self-checking bench for wm_cycle_timer (PHASE_LOG2=2, PRESCALE_DIV=4).
module tb_wm_cycle_timer;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wm_cycle_timer_if #(.CNT_W(CNT_W)) tif();

  wm_cycle_timer #(
    .CNT_W        (CNT_W),
    .PHASE_LOG2   (2),
    .PRESCALE_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  typedef struct {
    logic        start;
    logic [31:0] value;
    logic        hold;
    logic        abort;
    logic        expDone;
    logic        expBusy;
    logic [31:0] expRemaining;
    logic        expPhase;
  } vector_t;

  typedef struct {
    logic        done;
    logic        busy;
    logic [31:0] remaining;
    logic        phase;
    string       tag;
  } expect_t;

  vector_t vecs[$];
  expect_t expQ[$];
  int total = 0;
  int bad   = 0;

  function automatic vector_t vec(logic s, logic [31:0] v, logic h, logic a,
                                  logic d, logic b, logic [31:0] r, logic p);
    vector_t x;
    x.start = s; x.value = v; x.hold = h; x.abort = a;
    x.expDone = d; x.expBusy = b; x.expRemaining = r; x.expPhase = p;
    return x;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic checkOutput();
    expect_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard: empty queue at %0t", $time);
      return;
    end
    e = expQ.pop_front();
    checkValue({e.tag, " done"}, 32'(tif.timer_done), 32'(e.done));
    checkValue({e.tag, " busy"}, 32'(tif.busy), 32'(e.busy));
    checkValue({e.tag, " remaining"}, tif.remaining, e.remaining);
    checkValue({e.tag, " phase"}, 32'(tif.phase), 32'(e.phase));
  endtask

  task automatic applyStimulus(input vector_t v, input string tag);
    expect_t e;
    @(negedge clk);
    tif.timer_start = v.start;
    tif.timer_value = v.value;
    tif.hold        = v.hold;
    tif.abort       = v.abort;
    e.done = v.expDone; e.busy = v.expBusy; e.remaining = v.expRemaining;
    e.phase = v.expPhase; e.tag = tag;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

`ifdef WM_CYCLE_TIMER_PRESCALE_EN
  task automatic prescaleRun(input logic withHold, input int expLatency, input string tag);
    int foundAt;
    int pulses;
    foundAt = 0;
    pulses  = 0;
    @(negedge clk);
    tif.timer_start = 1'b1;
    tif.timer_value = 32'd3;
    tif.hold        = 1'b0;
    tif.abort       = 1'b0;
    @(posedge clk);
    #1;
    checkValue({tag, " load remaining"}, tif.remaining, 32'd3);
    checkValue({tag, " load busy"}, 32'(tif.busy), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tif.timer_start = 1'b0;
      tif.hold        = withHold && (k >= 6) && (k <= 9);
      @(posedge clk);
      #1;
      if (tif.timer_done) begin
        pulses++;
        if (foundAt == 0) foundAt = k;
      end
      if (withHold && k == 8) checkValue({tag, " frozen remaining"}, tif.remaining, 32'd2);
    end
    checkValue({tag, " latency"}, 32'(foundAt), 32'(expLatency));
    checkValue({tag, " pulses"}, 32'(pulses), 32'd1);
    checkValue({tag, " busy after"}, 32'(tif.busy), 32'd0);
  endtask
`endif

  initial begin
    reset           = 1'b1;
    tif.timer_start = 1'b0;
    tif.timer_value = '0;
    tif.hold        = 1'b0;
    tif.abort       = 1'b0;
    #3;
    checkValue("reset done", 32'(tif.timer_done), 32'd0);
    checkValue("reset busy", 32'(tif.busy), 32'd0);
    checkValue("reset remaining", tif.remaining, 32'd0);
    checkValue("reset phase", 32'(tif.phase), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

`ifdef WM_CYCLE_TIMER_PRESCALE_EN
    prescaleRun(1'b0, 12, "prescale");
    prescaleRun(1'b1, 17, "prescale hold");
`else
    // load 5 and expire
    vecs.push_back(vec(1, 5, 0, 0, 0, 1, 5, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 4, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 3, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(vec(0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1));
    // zero load acts as one
    vecs.push_back(vec(1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(vec(0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0));
    // hold mid-count, expiry with hold high, hold ignored in idle
    vecs.push_back(vec(1, 10, 0, 0, 0, 1, 10, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 9, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 8, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 7, 0));
    vecs.push_back(vec(0, 0, 1, 0, 0, 1, 7, 0));
    vecs.push_back(vec(0, 0, 1, 0, 0, 1, 7, 0));
    vecs.push_back(vec(0, 0, 1, 0, 0, 1, 7, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 7, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 6, 1));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 5, 1));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 4, 1));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 3, 1));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(vec(0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(vec(0, 0, 1, 0, 0, 0, 0, 0));
    // load straight into hold, release, then abort
    vecs.push_back(vec(1, 3, 1, 0, 0, 1, 3, 0));
    vecs.push_back(vec(0, 0, 1, 0, 0, 1, 3, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 3, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(vec(0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // abort together with start at tick 20
    applyStimulus(vec(1, 100, 0, 0, 0, 1, 100, 0), "abort load");
    for (int i = 1; i <= 19; i++) begin
      applyStimulus(vec(0, 0, 0, 0, 0, 1, 32'(100 - i), 1'((i >> 2) & 1)), $sformatf("abort tick%0d", i));
    end
    applyStimulus(vec(1, 50, 0, 1, 0, 0, 0, 0), "abort+start");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vec(0, 0, 0, 0, 0, 0, 0, 0), $sformatf("after abort%0d", i));
    end

    // restart with phase pattern
    applyStimulus(vec(1, 20, 0, 0, 0, 1, 20, 0), "restart load");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(vec(0, 0, 0, 0, 0, 1, 32'(20 - i), 1'((i >> 2) & 1)), $sformatf("first tick%0d", i));
    end
    applyStimulus(vec(1, 8, 0, 0, 0, 1, 8, 0), "restart");
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(vec(0, 0, 0, 0, 0, 1, 32'(8 - i), 1'((i >> 2) & 1)), $sformatf("restart tick%0d", i));
    end
    applyStimulus(vec(0, 0, 0, 0, 1, 0, 0, 0), "restart expire");
    applyStimulus(vec(0, 0, 0, 0, 0, 0, 0, 0), "restart idle");

    // asynchronous reset at remaining 3
    applyStimulus(vec(1, 5, 0, 0, 0, 1, 5, 0), "areset load");
    applyStimulus(vec(0, 0, 0, 0, 0, 1, 4, 0), "areset tick1");
    applyStimulus(vec(0, 0, 0, 0, 0, 1, 3, 0), "areset tick2");
    #2;
    reset = 1'b1;
    #1;
    checkValue("areset done", 32'(tif.timer_done), 32'd0);
    checkValue("areset busy", 32'(tif.busy), 32'd0);
    checkValue("areset remaining", tif.remaining, 32'd0);
    checkValue("areset phase", 32'(tif.phase), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vec(0, 0, 0, 0, 0, 0, 0, 0), $sformatf("post reset%0d", i));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
